// File: rtl/instr_fetch_if.sv
// Handshake bundle between the instruction fetch stage and whatever loads and
// consumes it. The master drives program load, start and stall; the slave issues instructions.
interface instr_fetch_if #(
    parameter int AW = 5,
    parameter int IW = 18
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stall;
    logic [IW-1:0] instruct;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   issued_count;
    logic          done;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, stall,
        input  instruct, instr_valid, pc, issued_count, done
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, stall,
        output instruct, instr_valid, pc, issued_count, done
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable program memory plus a PC that issues one
// instruction per clock from address 0 for a latched program length.
module instr_fetch #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int IW    = 18
) (
    input  logic          clock,
    input  logic          reset_n,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state;
    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_instr;
    logic          r_valid;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_len;
    logic          r_done;
    logic          w_idle;
    logic [AW:0]   w_len;

    // Loads and starts are only accepted while no run is in progress.
    always_comb begin
        w_idle = 1'b0;
        w_len  = bus.prog_len;
        if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
            w_idle = 1'b1;
        end else begin
            w_idle = 1'b0;
        end
        if (bus.prog_len > LP_DEPTH) begin
            w_len = LP_DEPTH;
        end else begin
            w_len = bus.prog_len;
        end
    end

    // Program memory write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (bus.load_en && w_idle) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Run-control FSM with all outputs registered; stall freezes every register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_instr <= {IW{1'b0}};
            r_valid <= 1'b0;
            r_pc    <= {AW{1'b0}};
            r_cnt   <= {(AW+1){1'b0}};
            r_len   <= {(AW+1){1'b0}};
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_valid <= 1'b0;
                    if (bus.start) begin
                        r_len <= w_len;
                        r_pc  <= {AW{1'b0}};
                        r_cnt <= {(AW+1){1'b0}};
                        if (w_len == {(AW+1){1'b0}}) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_done  <= 1'b0;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!bus.stall) begin
                        if (r_cnt < r_len) begin
                            // The write port is closed during FETCH, so this read never races a load.
                            r_instr <= r_mem[r_pc];
                            r_valid <= 1'b1;
                            r_pc    <= r_pc + AW'(1);
                            r_cnt   <= r_cnt + (AW+1)'(1);
                        end else begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instruct     = r_instr;
    assign bus.instr_valid  = r_valid;
    assign bus.pc           = r_pc;
    assign bus.issued_count = r_cnt;
    assign bus.done         = r_done;

endmodule
